// File: rtl/hamming_decode_arbiter.sv
// ---------------------------------------------------------------------------
// hamming_decode_arbiter
//
// Shares one external Hamming(7,4) decoder between two UART receive channels.
// Each channel owns a one-deep holding register. A round-robin scheduler
// issues one codeword at a time to the decoder. The decoded nibble is
// returned on a ready/valid output port, tagged with its source channel. A
// wait-state timeout guards against a decoder that never answers. Sticky
// flags record overflow and timeout events.
//
// Optional feature macro: HAMMING_ARB_STATS_EN
//   defined   -> per-channel saturating counters of nonzero-syndrome results
//   undefined -> err_cnt0/err_cnt1 are tied to 8'h00
//
// Parameters
//   TIMEOUT       maximum WAIT cycles before a request is abandoned (1..255)
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   in_valid[1:0] per-channel one-cycle codeword strobe
//   in_code0/1    7-bit codeword for channel 0 / channel 1
//   dec_ena       one-cycle request pulse to the decoder (ISSUE state)
//   dec_code      codeword under decode, stable from ISSUE back to IDLE
//   dec_valid     decoder result strobe
//   dec_data      decoded nibble from the decoder
//   dec_syndrome  syndrome from the decoder
//   out_valid     a result is held on the output
//   out_ready     consumer accepts the held result
//   out_ch        source channel of the held result
//   out_data      decoded nibble of the held result
//   out_syndrome  syndrome of the held result
//   clear_status  clears ovf, tmo and the error counters
//   ovf[1:0]      sticky per-channel overflow flags
//   tmo           sticky decoder-timeout flag
//   state_out     FSM state for debug (IDLE=00, ISSUE=01, WAIT=10)
//   err_cnt0/1    nonzero-syndrome result counts per channel
//
// Output handshake: the result transfers in a cycle where out_valid and
// out_ready are both high at the rising clock edge. out_valid stays high and
// out_ch/out_data/out_syndrome stay unchanged until that transfer happens.
// ---------------------------------------------------------------------------
module hamming_decode_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] in_valid,
   input  logic [6:0] in_code0,
   input  logic [6:0] in_code1,
   output logic       dec_ena,
   output logic [6:0] dec_code,
   input  logic       dec_valid,
   input  logic [3:0] dec_data,
   input  logic [2:0] dec_syndrome,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_ch,
   output logic [3:0] out_data,
   output logic [2:0] out_syndrome,
   input  logic       clear_status,
   output logic [1:0] ovf,
   output logic       tmo,
   output logic [1:0] state_out,
   output logic [7:0] err_cnt0,
   output logic [7:0] err_cnt1
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state;
   state_t     state_nx;

   logic [1:0] hold_full;
   logic [6:0] hold_code0;
   logic [6:0] hold_code1;
   logic       rr_ptr;
   logic       sel_q;
   logic [7:0] wait_cnt;

   logic       slot_free;
   logic       grant;
   logic       grant_ch;
   logic       load;
   logic       timeout_hit;
   logic [1:0] hold_free;
   logic [1:0] capture;
   logic [1:0] ovf_set;

   // -------------------------------------------------------------------------
   // FSM next-state and control decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_nx    = ST_IDLE;
      grant       = 1'b0;
      grant_ch    = 1'b0;
      load        = 1'b0;
      timeout_hit = 1'b0;
      dec_ena     = 1'b0;
      // The output slot counts as free when it is being drained this cycle,
      // so a new grant can overlap the consumer's acceptance.
      slot_free   = !out_valid || out_ready;

      case (state)
         ST_IDLE: begin
            if ((hold_full != 2'b00) && slot_free) begin
               grant    = 1'b1;
               grant_ch = (hold_full == 2'b11) ? rr_ptr : hold_full[1];
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            dec_ena = 1'b1;
            if (dec_valid) begin
               load = 1'b1;
            end else begin
               state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A result arriving on the timeout cycle still wins.
            if (dec_valid) begin
               load = 1'b1;
            end else if (wait_cnt == TIMEOUT_C) begin
               timeout_hit = 1'b1;
            end else begin
               state_nx = ST_WAIT;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign hold_free = grant ? (grant_ch ? 2'b10 : 2'b01) : 2'b00;

   // A hold accepts a new codeword when empty or when it is handed to the
   // decoder in the same cycle; otherwise the newcomer is dropped.
   assign capture = in_valid & (~hold_full | hold_free);
   assign ovf_set = in_valid & hold_full & ~hold_free;

   assign state_out = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // -------------------------------------------------------------------------
   // Holding registers, scheduler, wait counter, output register, flags
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full    <= 2'b00;
         hold_code0   <= 7'h00;
         hold_code1   <= 7'h00;
         rr_ptr       <= 1'b0;
         sel_q        <= 1'b0;
         dec_code     <= 7'h00;
         wait_cnt     <= 8'h00;
         out_valid    <= 1'b0;
         out_ch       <= 1'b0;
         out_data     <= 4'h0;
         out_syndrome <= 3'b000;
         ovf          <= 2'b00;
         tmo          <= 1'b0;
      end else begin
         if (capture[0]) begin
            hold_full[0] <= 1'b1;
            hold_code0   <= in_code0;
         end else if (hold_free[0]) begin
            hold_full[0] <= 1'b0;
         end

         if (capture[1]) begin
            hold_full[1] <= 1'b1;
            hold_code1   <= in_code1;
         end else if (hold_free[1]) begin
            hold_full[1] <= 1'b0;
         end

         if (grant) begin
            dec_code <= grant_ch ? hold_code1 : hold_code0;
            sel_q    <= grant_ch;
            rr_ptr   <= ~grant_ch;
         end

         // The ISSUE cycle counts as the first wait cycle, so the abandon
         // decision lands TIMEOUT cycles after ISSUE and the flag one later.
         if (state == ST_ISSUE) begin
            wait_cnt <= 8'h01;
         end else if ((state == ST_WAIT) && (state_nx == ST_WAIT)) begin
            wait_cnt <= wait_cnt + 8'h01;
         end else begin
            wait_cnt <= 8'h00;
         end

         if (load) begin
            out_valid    <= 1'b1;
            out_ch       <= sel_q;
            out_data     <= dec_data;
            out_syndrome <= dec_syndrome;
         end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            out_ch       <= 1'b0;
            out_data     <= 4'h0;
            out_syndrome <= 3'b000;
         end

         // Set events take priority over a simultaneous clear.
         ovf <= (clear_status ? 2'b00 : ovf) | ovf_set;
         tmo <= (clear_status ? 1'b0 : tmo) | timeout_hit;
      end
   end

   // -------------------------------------------------------------------------
   // Optional error statistics
   // -------------------------------------------------------------------------
`ifdef HAMMING_ARB_STATS_EN
   logic [7:0] err_q0;
   logic [7:0] err_q1;
   logic       err_inc0;
   logic       err_inc1;

   // Clear first, then count, so an increment coinciding with a clear
   // leaves the counter at one.
   function automatic logic [7:0] next_cnt(input logic [7:0] cur,
                                           input logic       inc,
                                           input logic       clr);
      logic [7:0] base;
      base = clr ? 8'h00 : cur;
      if (inc && (base != 8'hFF)) begin
         base = base + 8'h01;
      end
      return base;
   endfunction

   assign err_inc0 = load && (dec_syndrome != 3'b000) && !sel_q;
   assign err_inc1 = load && (dec_syndrome != 3'b000) && sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q0 <= 8'h00;
         err_q1 <= 8'h00;
      end else begin
         err_q0 <= next_cnt(err_q0, err_inc0, clear_status);
         err_q1 <= next_cnt(err_q1, err_inc1, clear_status);
      end
   end

   assign err_cnt0 = err_q0;
   assign err_cnt1 = err_q1;
`else
   assign err_cnt0 = 8'h00;
   assign err_cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hamming_decode_arbiter
//
// Bench for hamming_decode_arbiter (TIMEOUT=4). Contents:
//   - clock/reset generation
//   - a decoder responder that answers dec_ena after a chosen latency. It
//     either decodes the codeword with a reference Hamming(7,4) function or
//     returns forced values.
//   - driver tasks for the codeword inputs
//   - a scoreboard: expected {ch, data, syndrome} tuples are queued per
//     channel when a codeword is issued. A monitor pops and compares on every
//     output transfer.
//   - directed scenarios, a randomized run, and a final summary line
// ---------------------------------------------------------------------------
module tb_hamming_decode_arbiter;

   localparam int TMO = 4;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst;
   logic [1:0] in_valid;
   logic [6:0] in_code0;
   logic [6:0] in_code1;
   logic       dec_ena;
   logic [6:0] dec_code;
   logic       dec_valid;
   logic [3:0] dec_data;
   logic [2:0] dec_syndrome;
   logic       out_valid;
   logic       out_ready;
   logic       out_ch;
   logic [3:0] out_data;
   logic [2:0] out_syndrome;
   logic       clear_status;
   logic [1:0] ovf;
   logic       tmo;
   logic [1:0] state_out;
   logic [7:0] err_cnt0;
   logic [7:0] err_cnt1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   hamming_decode_arbiter #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_code0     (in_code0),
      .in_code1     (in_code1),
      .dec_ena      (dec_ena),
      .dec_code     (dec_code),
      .dec_valid    (dec_valid),
      .dec_data     (dec_data),
      .dec_syndrome (dec_syndrome),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ch       (out_ch),
      .out_data     (out_data),
      .out_syndrome (out_syndrome),
      .clear_status (clear_status),
      .ovf          (ovf),
      .tmo          (tmo),
      .state_out    (state_out),
      .err_cnt0     (err_cnt0),
      .err_cnt1     (err_cnt1)
   );

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic       got_ch_q[$];
   int         total = 0;
   int         bad   = 0;

   // responder controls (written by the main sequence only)
   int         rsp_lat    = 0;   // -1: decoder never answers
   bit         rsp_rand   = 1'b0;
   bit         rsp_force  = 1'b0;
   logic [3:0] rsp_fdata  = 4'h0;
   logic [2:0] rsp_fsyn   = 3'b000;
   int         inject_req = 0;   // bump to request one stray dec_valid pulse

   // Reference Hamming(7,4): bit i of the code sits at position i+1, and the
   // syndrome is the XOR of the positions of all set bits.
   // Result is {data[3:0], syndrome[2:0]}.
   function automatic logic [6:0] ham_ref(input logic [6:0] c);
      logic [6:0] fixed;
      int         syn;
      fixed = c;
      syn   = 0;
      for (int p = 1; p <= 7; p++) begin
         if (c[p-1]) syn = syn ^ p;
      end
      if (syn != 0) fixed[syn-1] = ~fixed[syn-1];
      return {fixed[6], fixed[5], fixed[4], fixed[2], 3'(syn)};
   endfunction

   function automatic logic [7:0] exp_tuple(input logic ch, input logic [6:0] c);
      if (rsp_force) return {ch, rsp_fdata, rsp_fsyn};
      return {ch, ham_ref(c)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      in_valid     = 2'b00;
      clear_status = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drive_in(input logic [1:0] v, input logic [6:0] c0,
                           input logic [6:0] c1, input bit expect_it);
      in_valid = v;
      in_code0 = c0;
      in_code1 = c1;
      if (expect_it) begin
         if (v[0]) exp_q0.push_back(exp_tuple(1'b0, c0));
         if (v[1]) exp_q1.push_back(exp_tuple(1'b1, c1));
      end
   endtask

   task automatic wait_for_valid(input string name, input int bound);
      int n;
      n = 0;
      while (!out_valid && (n < bound)) begin
         tick();
         n++;
      end
      check(name, 32'(out_valid), 1);
   endtask

   task automatic wait_empty(input int bound);
      int n;
      n = 0;
      while (((exp_q0.size() + exp_q1.size()) != 0) && (n < bound)) begin
         tick();
         n++;
      end
   endtask

   task automatic drain(input string name);
      wait_empty(300);
      check(name, 32'(exp_q0.size() + exp_q1.size()), 0);
   endtask

   // ---------------- decoder responder ----------------
   initial begin : responder
      int         lat;
      int         inj_seen;
      logic [6:0] code;
      logic [6:0] r;
      inj_seen     = 0;
      dec_valid    = 1'b0;
      dec_data     = 4'h0;
      dec_syndrome = 3'b000;
      forever begin
         @(posedge clk);
         #2;
         dec_valid = 1'b0;
         if (inject_req != inj_seen) begin
            inj_seen     = inject_req;
            dec_valid    = 1'b1;
            dec_data     = 4'h3;
            dec_syndrome = 3'b001;
         end else if (dec_ena && (rsp_lat >= 0)) begin
            lat  = rsp_rand ? int'($urandom_range(0, 3)) : rsp_lat;
            code = dec_code;
            repeat (lat) begin
               @(posedge clk);
               #2;
            end
            r = rsp_force ? {rsp_fdata, rsp_fsyn} : ham_ref(code);
            dec_valid    = 1'b1;
            dec_data     = r[6:3];
            dec_syndrome = r[2:0];
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [7:0] got;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            got = {out_ch, out_data, out_syndrome};
            got_ch_q.push_back(out_ch);
            total++;
            if (!out_ch && (exp_q0.size() != 0)) begin
               e = exp_q0.pop_front();
               if (got !== e) begin
                  bad++;
                  $display("FAIL out_tuple_ch0 actual=%h expected=%h", got, e);
               end
            end else if (out_ch && (exp_q1.size() != 0)) begin
               e = exp_q1.pop_front();
               if (got !== e) begin
                  bad++;
                  $display("FAIL out_tuple_ch1 actual=%h expected=%h", got, e);
               end
            end else begin
               bad++;
               $display("FAIL out_unexpected actual=%h expected=none", got);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "bench did not finish");
   end

   // ---------------- main sequence ----------------
   initial begin : main_seq
      int         ena_seen;
      int         ov_seen;
      logic [6:0] exp_first;
      logic [1:0] v;

      rst          = 1'b1;
      in_valid     = 2'b00;
      in_code0     = 7'h00;
      in_code1     = 7'h00;
      out_ready    = 1'b1;
      clear_status = 1'b0;

      // Reset state
      do_reset();
      check("rst_state", 32'(state_out), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_dec_ena", 32'(dec_ena), 0);
      check("rst_dec_code", 32'(dec_code), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_tmo", 32'(tmo), 0);
      check("rst_err_cnt0", 32'(err_cnt0), 0);

      // Single request with a forced decoder answer two cycles after dec_ena
      rsp_force = 1'b1;
      rsp_fdata = 4'hA;
      rsp_fsyn  = 3'b000;
      rsp_lat   = 2;
      drive_in(2'b01, 7'h55, 7'h00, 1);                   // cycle t
      check("single_ena_t", 32'(dec_ena), 0);
      tick(); in_valid = 2'b00;                           // t+1
      check("single_ena_t1", 32'(dec_ena), 0);
      tick();                                             // t+2
      check("single_ena_t2", 32'(dec_ena), 1);
      check("single_dec_code", 32'(dec_code), 32'h55);
      tick();                                             // t+3
      check("single_wait", 32'(state_out), 2);
      check("single_ena_t3", 32'(dec_ena), 0);
      tick();                                             // t+4: dec_valid
      check("single_out_early", 32'(out_valid), 0);
      tick();                                             // t+5
      check("single_out_valid", 32'(out_valid), 1);
      check("single_out_data", 32'(out_data), 32'hA);
      check("single_out_ch", 32'(out_ch), 0);
      check("single_idle", 32'(state_out), 0);
      drain("single_drain");
      rsp_force = 1'b0;

      // Simultaneous pair from reset, repeated, then single ch0 + pair.
      // rr_ptr points away from the last grant, so after a lone ch0 grant
      // the next contested pair starts with ch1.
      do_reset();
      rsp_lat = 1;
      got_ch_q.delete();
      drive_in(2'b11, 7'h0F, 7'h70, 1); tick(); in_valid = 2'b00;
      drain("pair1_drain");
      drive_in(2'b11, 7'h0F, 7'h70, 1); tick(); in_valid = 2'b00;
      drain("pair2_drain");
      drive_in(2'b01, 7'h44, 7'h00, 1); tick(); in_valid = 2'b00;
      drain("lone_drain");
      drive_in(2'b11, 7'h21, 7'h7E, 1); tick(); in_valid = 2'b00;
      drain("pair3_drain");
      check("rr_count", 32'(got_ch_q.size()), 7);
      check("rr_order0", 32'(got_ch_q[0]), 0);
      check("rr_order1", 32'(got_ch_q[1]), 1);
      check("rr_order2", 32'(got_ch_q[2]), 0);
      check("rr_order3", 32'(got_ch_q[3]), 1);
      check("rr_order5", 32'(got_ch_q[5]), 1);
      check("rr_order6", 32'(got_ch_q[6]), 0);

      // Backpressure: both holds full, consumer stalls
      do_reset();
      rsp_lat   = 0;
      out_ready = 1'b0;
      drive_in(2'b11, 7'h2A, 7'h13, 1); tick(); in_valid = 2'b00;
      wait_for_valid("bp_first_out", 20);
      exp_first = ham_ref(7'h2A);
      ena_seen  = 0;
      for (int i = 0; i < 8; i++) begin
         if (dec_ena) ena_seen++;
         check("bp_data_stable", 32'(out_data), 32'(exp_first[6:3]));
         tick();
      end
      check("bp_no_second_ena", 32'(ena_seen), 0);
      check("bp_out_ch", 32'(out_ch), 0);
      out_ready = 1'b1;
      drain("bp_drain");

      // Overflow on channel 1 while it is blocked behind a held result
      do_reset();
      rsp_lat   = 1;
      out_ready = 1'b0;
      drive_in(2'b01, 7'h3C, 7'h00, 1); tick(); in_valid = 2'b00;
      wait_for_valid("ovf_first_out", 20);
      drive_in(2'b10, 7'h00, 7'h66, 1); tick(); in_valid = 2'b00;
      tick();
      drive_in(2'b10, 7'h00, 7'h11, 0); tick(); in_valid = 2'b00;
      check("ovf_set", 32'(ovf), 32'h2);
      clear_status = 1'b1;
      drive_in(2'b10, 7'h00, 7'h22, 0); tick();
      clear_status = 1'b0;
      in_valid     = 2'b00;
      check("ovf_set_wins", 32'(ovf), 32'h2);
      out_ready = 1'b1;
      drain("ovf_drain");
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      check("ovf_cleared", 32'(ovf), 0);

      // Timeout with a silent decoder, then a stray late strobe
      do_reset();
      rsp_lat = -1;
      drive_in(2'b01, 7'h5A, 7'h00, 0);                   // t
      tick(); in_valid = 2'b00;                           // t+1
      tick();                                             // t+2 ISSUE
      check("tmo_issue_ena", 32'(dec_ena), 1);
      repeat (TMO) tick();                                // t+6
      check("tmo_not_yet", 32'(tmo), 0);
      check("tmo_still_wait", 32'(state_out), 2);
      tick();                                             // t+7
      check("tmo_set", 32'(tmo), 1);
      check("tmo_state_idle", 32'(state_out), 0);
      inject_req++;
      tick(); tick(); tick();
      check("tmo_late_ignored", 32'(out_valid), 0);
      check("tmo_late_idle", 32'(state_out), 0);
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      check("tmo_cleared", 32'(tmo), 0);

      // Reset mid-operation: holds and in-flight request discarded
      drive_in(2'b11, 7'h0A, 7'h0B, 0); tick(); in_valid = 2'b00;
      tick(); tick();
      check("midrst_in_wait", 32'(state_out), 2);
      rst = 1'b1; tick(); rst = 1'b0;
      inject_req++;
      ena_seen = 0;
      ov_seen  = 0;
      for (int i = 0; i < 6; i++) begin
         if (dec_ena) ena_seen++;
         if (out_valid) ov_seen++;
         tick();
      end
      check("midrst_no_ena", 32'(ena_seen), 0);
      check("midrst_no_out", 32'(ov_seen), 0);
      check("midrst_idle", 32'(state_out), 0);

      // Error statistics
      do_reset();
      rsp_lat   = 0;
      rsp_force = 1'b1;
      rsp_fdata = 4'h6;
      rsp_fsyn  = 3'b101;
`ifdef HAMMING_ARB_STATS_EN
      for (int i = 0; i < 300; i++) begin
         drive_in(2'b01, 7'($urandom), 7'h00, 1); tick(); in_valid = 2'b00;
         wait_empty(50);
      end
      drain("stats_drain");
      check("stats_cnt0_sat", 32'(err_cnt0), 255);
      check("stats_cnt1", 32'(err_cnt1), 0);
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      check("stats_cnt0_clr", 32'(err_cnt0), 0);
`else
      for (int i = 0; i < 4; i++) begin
         drive_in(2'b11, 7'($urandom), 7'($urandom), 1); tick(); in_valid = 2'b00;
         wait_empty(50);
      end
      drain("stats_drain");
      check("stats_off_cnt0", 32'(err_cnt0), 0);
      check("stats_off_cnt1", 32'(err_cnt1), 0);
`endif
      rsp_force = 1'b0;

      // Randomized traffic: at most one outstanding codeword per channel, so
      // holds never overflow; decoder latency and consumer stalls random.
      do_reset();
      rsp_rand = 1'b1;
      for (int i = 0; i < 600; i++) begin
         v[0] = (exp_q0.size() == 0) && ($urandom_range(0, 2) == 0);
         v[1] = (exp_q1.size() == 0) && ($urandom_range(0, 2) == 0);
         drive_in(v, 7'($urandom), 7'($urandom), 1);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 2'b00;
      out_ready = 1'b1;
      drain("rand_drain");
      check("rand_no_ovf", 32'(ovf), 0);
      check("rand_no_tmo", 32'(tmo), 0);
      rsp_rand = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
